secuenciador_fsm: RTL and testbench
===================================

SECUENCIADOR_FSM -- requirements
Module: secuenciador_fsm

Interface
REQ-001 The module SHALL have parameter ANCHO, default 8, giving the number of bits serialised per run.
REQ-002 The module SHALL have parameter CW, default 4, giving the width of cuenta; CW SHALL be at least clog2(ANCHO+1).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-low reset.
REQ-005 Port start  input  1  requests a run; it is sampled only in IDLE.
REQ-006 Port dato  input  ANCHO  is the word to serialise; it is captured on the edge that accepts start.
REQ-007 Port y_in  input  1  carries the detector FSM output y.
REQ-008 Port a_out  output  1  drives the detector FSM input a.
REQ-009 Port fsm_rst  output  1  drives the detector FSM reset, active-high.
REQ-010 Port busy  output  1  is high while a run is in progress.
REQ-011 Port done  output  1  is a one-cycle pulse at run completion.
REQ-012 Port cuenta  output  CW  holds the number of y_in=1 samples in the last run.

Function
REQ-013 The state machine SHALL have states IDLE, SHIFT, FLUSH and DONE, plus an internal bit index k in the range 0..ANCHO-1.
REQ-014 In IDLE, if start=1 at a rising edge, the block SHALL load dato into an internal register, clear cuenta to 0, set k=0 and enter SHIFT; otherwise it SHALL stay in IDLE.
REQ-015 In SHIFT, a_out SHALL equal dato_reg[ANCHO-1-k] (MSB first); each edge SHALL increment k, and the edge with k=ANCHO-1 SHALL enter FLUSH.
REQ-016 FLUSH SHALL last exactly one cycle with a_out=0, then enter DONE.
REQ-017 DONE SHALL last exactly one cycle, then enter IDLE.
REQ-018 y_in SHALL be sampled on the edges ending SHIFT cycles k=1..ANCHO-1 and the FLUSH cycle, giving ANCHO samples (one-cycle detector latency); each sample equal to 1 SHALL increment cuenta by 1.
REQ-019 cuenta SHALL saturate at 2^CW-1 and never wrap.
REQ-020 y_in SHALL be ignored in IDLE, in DONE, and in the SHIFT cycle with k=0.
REQ-021 fsm_rst SHALL be 1 in IDLE and DONE, and 0 in SHIFT and FLUSH.
REQ-022 a_out SHALL be 0 in every state other than SHIFT.
REQ-023 busy SHALL be 1 exactly in SHIFT and FLUSH; done SHALL be 1 exactly in DONE.
REQ-024 When start is sampled at edge E0, done SHALL be high only between edge E0+ANCHO+1 and edge E0+ANCHO+2.
REQ-025 start asserted in SHIFT, FLUSH or DONE SHALL be ignored and SHALL NOT be queued; a change of dato during a run SHALL NOT affect the run.
REQ-026 cuenta SHALL hold its value after DONE until the next accepted start.
REQ-027 Holding start high continuously SHALL start back-to-back runs with exactly one IDLE cycle between DONE and the next SHIFT.

Reset
REQ-028 While reset=0, regardless of clk, the block SHALL be in IDLE with k=0, dato_reg=0, cuenta=0, a_out=0, busy=0, done=0 and fsm_rst=1.
REQ-029 A reset asserted mid-run SHALL abort the run immediately with no done pulse; the first start accepted after reset release SHALL begin a fresh run.

Verification
All scenarios use a bench model in which y_in equals a_out delayed by one clock and ANCHO=8.
REQ-030 Scenario: dato=8'hA5, start pulsed for 1 cycle -> a_out sequence 1,0,1,0,0,1,0,1; busy high for 9 cycles; done high in the 10th cycle after the start edge; cuenta=4.
REQ-031 Scenario: dato=8'hFF, then dato=8'h00 -> cuenta=8 after the first run, then cuenta=0 after the second.
REQ-032 Scenario: start pulsed at SHIFT k=3, then again during DONE -> exactly one done pulse; state returns to IDLE and stays there.
REQ-033 Scenario: reset=0 at SHIFT k=5 -> all outputs at reset values asynchronously, with no done pulse; a restart with dato=8'h81 -> cuenta=2.
REQ-034 Scenario: start held at 1 with dato=8'h0F -> two consecutive runs with done pulses 11 cycles apart, fsm_rst=1 during DONE and IDLE, and cuenta=4 each run.
REQ-035 Scenario: y_in forced to 1 constantly with CW=3 -> cuenta saturates at 7.

Source files
------------

// File: rtl/secuenciador_fsm.sv
// Serialises a captured word MSB-first into an external detector FSM and
// counts how many of the detector's y outputs were high over the run.
module secuenciador_fsm #(
  parameter int ANCHO = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ANCHO-1:0] dato,
  input  logic             y_in,
  output logic             a_out,
  output logic             fsm_rst,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cuenta,
  output logic [1:0]       o_estado
);

  localparam int KW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } estado_t;

  estado_t          r_estado;
  logic [KW-1:0]    r_k;
  logic [ANCHO-1:0] r_dato;

  logic [KW-1:0]    w_k_next;
  logic [KW-1:0]    w_sel;
  logic             w_cuenta_llena;

  assign w_k_next       = r_k + KW'(1);
  assign w_sel          = KW'(ANCHO - 1) - w_k_next;
  assign w_cuenta_llena = (cuenta == {CW{1'b1}});
  assign o_estado       = r_estado;

  // Outputs are registered: each edge loads the value the next state presents.
  // The detector answers one cycle late, so the k=0 cycle's y_in is stale
  // and the FLUSH cycle collects the answer to the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= IDLE;
      r_k      <= '0;
      r_dato   <= '0;
      cuenta   <= '0;
      a_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fsm_rst  <= 1'b1;
    end else begin
      case (r_estado)
        IDLE: begin
          if (start) begin
            r_dato   <= dato;
            cuenta   <= '0;
            r_k      <= '0;
            a_out    <= dato[ANCHO-1];
            busy     <= 1'b1;
            fsm_rst  <= 1'b0;
            r_estado <= SHIFT;
          end
        end
        SHIFT: begin
          if ((r_k != '0) && y_in && !w_cuenta_llena) begin
            cuenta <= cuenta + CW'(1);
          end
          if (r_k == KW'(ANCHO - 1)) begin
            a_out    <= 1'b0;
            r_estado <= FLUSH;
          end else begin
            r_k   <= w_k_next;
            a_out <= r_dato[w_sel];
          end
        end
        FLUSH: begin
          if (y_in && !w_cuenta_llena) begin
            cuenta <= cuenta + CW'(1);
          end
          a_out    <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          fsm_rst  <= 1'b1;
          r_estado <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          r_estado <= IDLE;
        end
        default: begin
          r_estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_fsm.sv
// Bench for secuenciador_fsm: the detector is modelled as y_in = a_out delayed
// one clock; a second instance with CW=3 and y_in tied high checks saturation.
module tb_secuenciador_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dato = 8'h00;
  logic       y_in = 1'b0;
  logic       a_out, fsm_rst, busy, done;
  logic [3:0] cuenta;
  logic [1:0] estado;

  logic       y_one = 1'b1;
  logic       a_out_s, fsm_rst_s, busy_s, done_s;
  logic [2:0] cuenta_s;
  logic [1:0] estado_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [3:0] exp_q[$];

  secuenciador_fsm #(.ANCHO(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dato(dato), .y_in(y_in),
    .a_out(a_out), .fsm_rst(fsm_rst), .busy(busy), .done(done),
    .cuenta(cuenta), .o_estado(estado)
  );

  secuenciador_fsm #(.ANCHO(8), .CW(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .dato(dato), .y_in(y_one),
    .a_out(a_out_s), .fsm_rst(fsm_rst_s), .busy(busy_s), .done(done_s),
    .cuenta(cuenta_s), .o_estado(estado_s)
  );

  // ---------------- clock / reset / detector model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) y_in <= a_out;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ones(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // One-cycle start pulse; returns whether done arrived, edges from accept to
  // done, and cuenta just after the accepting edge.
  task automatic run_word(input logic [7:0] d, output bit ok, output int lat,
                          output logic [3:0] c0);
    int e0;
    dato = d;
    start = 1'b1;
    exp_q.push_back(ones(d));
    tick();
    start = 1'b0;
    e0 = cyc;
    c0 = cuenta;
    wait_done(ok);
    lat = cyc - e0;
  endtask

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'hx;
    return exp_q.pop_front();
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if ({a_out, busy, done, fsm_rst} !== 4'b0001) begin errors++; $display("FAIL reset_outputs got=%b exp=0001", {a_out, busy, done, fsm_rst}); end
    checks++; if (cuenta !== 4'd0) begin errors++; $display("FAIL reset_cuenta got=%0d exp=0", cuenta); end
    checks++; if (estado !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", estado); end
    checks++; if (cuenta_s !== 3'd0) begin errors++; $display("FAIL reset_cuenta_sat got=%0d exp=0", cuenta_s); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_a5();
    logic [7:0] bits;
    logic [3:0] e;
    int e0;
    bits = 8'hA5;
    dato = bits;
    start = 1'b1;
    exp_q.push_back(ones(bits));
    tick();
    start = 1'b0;
    dato = 8'h3C;
    e0 = cyc;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({a_out, busy, fsm_rst, done} !== {bits[7-i], 3'b100}) begin errors++; $display("FAIL a5_shift[%0d] a/busy/rst/done got=%b exp=%b", i, {a_out, busy, fsm_rst, done}, {bits[7-i], 3'b100}); end
      tick();
    end
    checks++; if ({a_out, busy, fsm_rst, done} !== 4'b0100) begin errors++; $display("FAIL a5_flush got=%b exp=0100", {a_out, busy, fsm_rst, done}); end
    tick();
    checks++; if ({a_out, busy, fsm_rst, done} !== 4'b0011) begin errors++; $display("FAIL a5_done got=%b exp=0011", {a_out, busy, fsm_rst, done}); end
    checks++; if (cyc - e0 !== 9) begin errors++; $display("FAIL a5_done_latency got=%0d exp=9", cyc - e0); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL a5_cuenta got=%0d exp=%0d", cuenta, e); end
    tick();
    checks++; if ({done, busy, cuenta} !== {2'b00, 4'd4}) begin errors++; $display("FAIL a5_idle_hold done/busy/cuenta got=%b exp=%b", {done, busy, cuenta}, {2'b00, 4'd4}); end
  endtask

  task automatic test_two_runs();
    bit ok;
    int lat;
    logic [3:0] c0, e;
    run_word(8'hFF, ok, lat, c0);
    checks++; if (!ok) begin errors++; $display("FAIL ff_done_timeout got=none exp=done"); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL ff_latency got=%0d exp=9", lat); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL ff_cuenta got=%0d exp=%0d", cuenta, e); end
    tick(); tick(); tick();
    checks++; if (cuenta !== 4'd8) begin errors++; $display("FAIL ff_cuenta_hold got=%0d exp=8", cuenta); end
    run_word(8'h00, ok, lat, c0);
    checks++; if (c0 !== 4'd0) begin errors++; $display("FAIL zero_clear_on_start got=%0d exp=0", c0); end
    checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout got=none exp=done"); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL zero_cuenta got=%0d exp=%0d", cuenta, e); end
    tick();
  endtask

  task automatic test_ignore_start();
    bit ok;
    int pulses;
    logic [3:0] e;
    dato = 8'hA5;
    start = 1'b1;
    exp_q.push_back(ones(8'hA5));
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    dato = 8'h00;
    tick();
    start = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout got=none exp=done"); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL ign_cuenta got=%0d exp=%0d", cuenta, e); end
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ign_extra_activity got=%0d exp=0", pulses); end
    checks++; if (estado !== 2'd0) begin errors++; $display("FAIL ign_final_state got=%0d exp=0", estado); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat, pulses;
    logic [3:0] c0, e;
    dato = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++; if ({a_out, busy, done, fsm_rst} !== 4'b0001) begin errors++; $display("FAIL rmid_async_outputs got=%b exp=0001", {a_out, busy, done, fsm_rst}); end
    checks++; if ({estado, cuenta} !== 6'd0) begin errors++; $display("FAIL rmid_state_cuenta got=%b exp=000000", {estado, cuenta}); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", pulses); end
    run_word(8'h81, ok, lat, c0);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_restart_timeout got=none exp=done"); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL rmid_restart_cuenta got=%0d exp=%0d", cuenta, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t1, t2;
    logic [3:0] e;
    dato = 8'h0F;
    start = 1'b1;
    exp_q.push_back(ones(8'h0F));
    exp_q.push_back(ones(8'h0F));
    wait_done(ok);
    t1 = cyc;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got=none exp=done"); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL b2b_first_cuenta got=%0d exp=%0d", cuenta, e); end
    checks++; if ({fsm_rst, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done_rst got=%b exp=10", {fsm_rst, busy}); end
    tick();
    checks++; if ({busy, done, fsm_rst, a_out} !== 4'b0010) begin errors++; $display("FAIL b2b_idle_gap got=%b exp=0010", {busy, done, fsm_rst, a_out}); end
    tick();
    checks++; if ({busy, fsm_rst} !== 2'b10) begin errors++; $display("FAIL b2b_restart got=%b exp=10", {busy, fsm_rst}); end
    wait_done(ok);
    t2 = cyc;
    start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got=none exp=done"); end
    checks++; if (t2 - t1 !== 11) begin errors++; $display("FAIL b2b_spacing got=%0d exp=11", t2 - t1); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL b2b_second_cuenta got=%0d exp=%0d", cuenta, e); end
    tick(); tick();
    checks++; if ({busy, fsm_rst} !== 2'b01) begin errors++; $display("FAIL b2b_stop got=%b exp=01", {busy, fsm_rst}); end
  endtask

  task automatic test_saturation();
    bit ok;
    int lat;
    logic [3:0] c0, e;
    run_word(8'h00, ok, lat, c0);
    checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout got=none exp=done"); end
    e = pop_exp();
    checks++; if (cuenta !== e) begin errors++; $display("FAIL sat_main_cuenta got=%0d exp=%0d", cuenta, e); end
    checks++; if (cuenta_s !== 3'd7) begin errors++; $display("FAIL sat_cuenta got=%0d exp=7", cuenta_s); end
    tick();
    checks++; if (cuenta_s !== 3'd7) begin errors++; $display("FAIL sat_cuenta_hold got=%0d exp=7", cuenta_s); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_a5();
    test_two_runs();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
